// File: rtl/syncfifo_flex.sv
// -----------------------------------------------------------------------------
// syncfifo_flex
//   Parametrised single-clock FIFO with programmable almost-full/almost-empty
//   thresholds, sticky overflow/underflow flags and a selectable output mode:
//   standard registered read (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (storage is not cleared)
//   we / din     write request and write data
//   re           read request (FWFT: pop of the head word)
//   dout         read data (registered in both modes)
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                             sticky error flags
//   clr_err      clears both error flags; a same-cycle error wins
// -----------------------------------------------------------------------------
module syncfifo_flex #(
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned AF_LVL = 6,
  parameter int unsigned AE_LVL = 2,
  parameter int unsigned FWFT   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam int unsigned CW = AW + 1;

  // Elaboration-time sanity checks on the parameter set.
  if (DEPTH < 4) begin : g_chk_depth_min
    $error("syncfifo_flex: DEPTH must be >= 4");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth_pow2
    $error("syncfifo_flex: DEPTH must be a power of 2");
  end
  if (AW != $clog2(DEPTH)) begin : g_chk_aw
    $error("syncfifo_flex: AW must equal clog2(DEPTH)");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH - 1) begin : g_chk_af
    $error("syncfifo_flex: AF_LVL out of range 1..DEPTH-1");
  end
  if (AE_LVL < 1 || AE_LVL > DEPTH - 1) begin : g_chk_ae
    $error("syncfifo_flex: AE_LVL out of range 1..DEPTH-1");
  end

  // State
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          rd_ok;
  logic          wr_ok;

  // Accept decisions on pre-edge state; a read frees the slot a full-FIFO write needs.
  always_comb begin
    rd_ok = re & ~empty_q;
    wr_ok = we & (~full_q | rd_ok);
  end

  // Next-state for storage, pointers, occupancy and registered status.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle rejected access re-sets its flag.
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (we & ~wr_ok) ovf_d = 1'b1;
    if (re & ~rd_ok) udf_d = 1'b1;

    if (FWFT == 0) begin
      if (rd_ok) dout_d = mem_q[rd_ptr_q];
    end else begin
      // Preload the post-edge head; mem_d already carries this edge's write,
      // which covers the word landing in an empty (or draining) FIFO.
      if (count_d != '0) dout_d = mem_d[rd_ptr_d];
    end

    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AF_LVL));
    aempty_d = (count_d <= CW'(AE_LVL));
  end

  // Storage array: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign dout         = dout_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_syncfifo_flex.sv
// -----------------------------------------------------------------------------
// tb_syncfifo_flex
//   Drives one stimulus stream into a standard-read and an FWFT instance of
//   syncfifo_flex and checks both against a queue-based reference model.
//   Read data expected from the standard instance goes through a scoreboard
//   ring written by the model and drained by the monitor.
// -----------------------------------------------------------------------------
module tb_syncfifo_flex;

  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned AF_LVL = 6;
  localparam int unsigned AE_LVL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout_s, dout_f;
  logic          full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [AW:0]   count_s, count_f;

  always #5 clk = ~clk;

  syncfifo_flex #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .AF_LVL(AF_LVL),
                  .AE_LVL(AE_LVL), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .dout(dout_s),
    .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .count(count_s), .overflow(ovf_s), .underflow(udf_s), .clr_err(clr_err));

  syncfifo_flex #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .AF_LVL(AF_LVL),
                  .AE_LVL(AE_LVL), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .dout(dout_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(count_f), .overflow(ovf_f), .underflow(udf_f), .clr_err(clr_err));

  // Reference model state (written only by the model process)
  logic [DW-1:0] q [$];
  bit            m_ovf = 0;
  bit            m_udf = 0;
  bit            m_valid = 0;
  bit            m_rd_ok, m_wr_ok;
  logic [DW-1:0] sb [4096];
  int unsigned   sb_wi = 0;

  // Monitor state
  int unsigned   sb_ri = 0;
  logic [DW-1:0] last_s = '0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue updated with the accept rules each edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf   = 0;
      m_udf   = 0;
      m_valid = 1;
      sb[sb_wi % 4096] = '0;   // standard dout presents 0 after reset
      sb_wi++;
    end else begin
      m_rd_ok = re && (q.size() > 0);
      m_wr_ok = we && ((q.size() < DEPTH) || m_rd_ok);
      if (clr_err) begin
        m_ovf = 0;
        m_udf = 0;
      end
      if (we && !m_wr_ok) m_ovf = 1;
      if (re && !m_rd_ok) m_udf = 1;
      if (m_rd_ok) begin
        sb[sb_wi % 4096] = q.pop_front();
        sb_wi++;
      end
      if (m_wr_ok) q.push_back(din);
    end
  end

  // Monitor: samples on the falling edge, half a cycle after each update.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("count_std",  int'(count_s), q.size());
      chk("count_fwft", int'(count_f), q.size());
      chk("full_std",   int'(full_s),  int'(q.size() == DEPTH));
      chk("full_fwft",  int'(full_f),  int'(q.size() == DEPTH));
      chk("empty_std",  int'(empty_s), int'(q.size() == 0));
      chk("empty_fwft", int'(empty_f), int'(q.size() == 0));
      chk("afull_std",  int'(af_s),    int'(q.size() >= AF_LVL));
      chk("afull_fwft", int'(af_f),    int'(q.size() >= AF_LVL));
      chk("aempty_std", int'(ae_s),    int'(q.size() <= AE_LVL));
      chk("aempty_fwft",int'(ae_f),    int'(q.size() <= AE_LVL));
      chk("ovf_std",    int'(ovf_s),   int'(m_ovf));
      chk("ovf_fwft",   int'(ovf_f),   int'(m_ovf));
      chk("udf_std",    int'(udf_s),   int'(m_udf));
      chk("udf_fwft",   int'(udf_f),   int'(m_udf));
      if (sb_ri != sb_wi) begin
        last_s = sb[sb_ri % 4096];
        sb_ri++;
        chk("rdata_std", int'(dout_s), int'(last_s));
      end else begin
        chk("dout_hold_std", int'(dout_s), int'(last_s));
      end
      if (q.size() > 0) chk("head_fwft", int'(dout_f), int'(q[0]));
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit c, input bit rs);
    we = w; din = d; re = r; clr_err = c; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    #1;
    // Reset
    repeat (3) cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0);
    // Fill through the thresholds, then a rejected 9th write
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);
    // Drain in order, then a rejected read
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 1, 1, 0);           // clear loses to a new underflow
    cyc(0, 8'h00, 0, 1, 0);
    // Full FIFO, simultaneous write/read across pointer wrap
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, 0);
    // Single word fall-through, then write+read on empty
    cyc(1, 8'h5C, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(1, 8'h33, 1, 0, 0);
    cyc(0, 8'h00, 1, 1, 0);
    // Mid-stream reset at count=5
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hE1, 0, 0, 0);
    cyc(1, 8'hE2, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    // Randomised traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 3000; i++) begin
      bit heavy_w;
      heavy_w = ((i / 40) % 2) == 0;
      v = 8'($urandom);
      cyc(($urandom_range(0, 9) < (heavy_w ? 8 : 3)), v,
          ($urandom_range(0, 9) < (heavy_w ? 3 : 8)),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
    end
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
